// File: rtl/activation_execution.sv
// activation_execution
//   Multi-mode elementwise activation engine. Each launch streams
//   ceil(length/TILE_ELEMS) tiles from buffer x_buffer_id, applies the selected
//   activation (IDENTITY / RELU / LEAKY / CLAMP) to every element and writes the
//   result tile to buffer dest_buffer_id. One tile is in flight at a time; the
//   only storage is the registered output tile.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | waiting for start; configuration inputs are sampled on start
//   WAIT_RD | read request issued for vec_tile_index, waiting for valid
//   WRITE   | activated tile presented, waiting for vec_write_ready
//   DONE    | one-cycle completion pulse, then IDLE
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   start, abort              launch (IDLE only) / cancel (any non-IDLE state)
//   mode, leaky_shift,
//   clamp_max                 activation configuration, latched on launch
//   x_buffer_id,
//   dest_buffer_id, length    source / destination buffers and element count
//   busy, done, aborted       status; done and aborted are one-cycle pulses
//   vec_read_*                tile read request / response
//   vec_write_*               tile write request with ready backpressure
//   vec_tile_index            index of the tile currently being read/written

module activation_execution #(
    parameter int DATA_WIDTH   = 8,
    parameter int TILE_ELEMS   = 32,
    parameter int LEN_WIDTH    = 10,
    parameter int BUF_ID_WIDTH = 5
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               abort,
    input  logic [1:0]                         mode,
    input  logic [2:0]                         leaky_shift,
    input  logic [DATA_WIDTH-1:0]              clamp_max,
    input  logic [BUF_ID_WIDTH-1:0]            x_buffer_id,
    input  logic [BUF_ID_WIDTH-1:0]            dest_buffer_id,
    input  logic [LEN_WIDTH-1:0]               length,
    output logic                               busy,
    output logic                               done,
    output logic                               aborted,
    output logic                               vec_read_enable,
    output logic [BUF_ID_WIDTH-1:0]            vec_read_buffer_id,
    input  logic [TILE_ELEMS*DATA_WIDTH-1:0]   vec_read_tile,
    input  logic                               vec_read_valid,
    output logic                               vec_write_enable,
    input  logic                               vec_write_ready,
    output logic [BUF_ID_WIDTH-1:0]            vec_write_buffer_id,
    output logic [TILE_ELEMS*DATA_WIDTH-1:0]   vec_write_tile,
    output logic [LEN_WIDTH-1:0]               vec_tile_index
);

    localparam int TILE_W = TILE_ELEMS * DATA_WIDTH;
    localparam int CNT_W  = LEN_WIDTH + 1;
    // wide enough for tile_index*TILE_ELEMS + lane without overflow
    localparam int BASE_W = LEN_WIDTH + $clog2(TILE_ELEMS) + 1;

    localparam logic [1:0] MODE_IDENTITY = 2'd0;
    localparam logic [1:0] MODE_RELU     = 2'd1;
    localparam logic [1:0] MODE_LEAKY    = 2'd2;
    localparam logic [1:0] MODE_CLAMP    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_RD = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0]                   mode_q;
    logic [2:0]                   shift_q;
    logic signed [DATA_WIDTH-1:0] clamp_q;
    logic [LEN_WIDTH-1:0]         len_q;
    logic [LEN_WIDTH-1:0]         last_idx_q;

    logic                         launch;
    logic                         len_zero;
    logic                         is_last;
    logic                         write_accept;
    logic                         read_capture;
    logic [CNT_W-1:0]             tile_count;
    logic [BASE_W-1:0]            tile_base;
    logic [BASE_W-1:0]            len_ext;
    logic [TILE_W-1:0]            act_tile;

    // ------------------------------------------------------------------
    // Per-element activation. Results never widen; LEAKY relies on the
    // arithmetic shift for floor rounding of negative values.
    // ------------------------------------------------------------------
    function automatic logic [DATA_WIDTH-1:0] activate(
        input logic signed [DATA_WIDTH-1:0] x,
        input logic [1:0]                   sel,
        input logic [2:0]                   shamt,
        input logic signed [DATA_WIDTH-1:0] cmax
    );
        logic [DATA_WIDTH-1:0] y;
        y = x;
        case (sel)
            MODE_RELU: begin
                if (x[DATA_WIDTH-1]) y = '0;
            end
            MODE_LEAKY: begin
                if (x[DATA_WIDTH-1]) y = x >>> shamt;
            end
            MODE_CLAMP: begin
                // a negative bound makes the clamp window empty: everything is 0
                if (cmax[DATA_WIDTH-1] || x[DATA_WIDTH-1]) y = '0;
                else if (x > cmax)                         y = cmax;
            end
            default: y = x;
        endcase
        return y;
    endfunction

    // ------------------------------------------------------------------
    // Lane datapath: activate each element, zero lanes past length.
    // ------------------------------------------------------------------
    assign tile_base = BASE_W'(vec_tile_index) * BASE_W'(TILE_ELEMS);
    assign len_ext   = BASE_W'(len_q);

    for (genvar g = 0; g < TILE_ELEMS; g++) begin : g_lane
        logic [BASE_W-1:0] pos;
        assign pos = tile_base + BASE_W'(g);
        assign act_tile[g*DATA_WIDTH +: DATA_WIDTH] =
            (pos < len_ext)
                ? activate($signed(vec_read_tile[g*DATA_WIDTH +: DATA_WIDTH]),
                           mode_q, shift_q, clamp_q)
                : '0;
    end

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    assign launch       = (state == S_IDLE) && start;
    assign len_zero     = (length == '0);
    assign is_last      = (vec_tile_index == last_idx_q);
    assign write_accept = (state == S_WRITE) && vec_write_ready && !abort;
    assign read_capture = (state == S_WAIT_RD) && vec_read_valid && !abort;
    assign tile_count   = (CNT_W'(length) + CNT_W'(TILE_ELEMS - 1)) / CNT_W'(TILE_ELEMS);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // ------------------------------------------------------------------
    // FSM: next state. Abort wins over valid/ready in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) state_next = len_zero ? S_DONE : S_WAIT_RD;
            end
            S_WAIT_RD: begin
                if (abort)               state_next = S_IDLE;
                else if (vec_read_valid) state_next = S_WRITE;
            end
            S_WRITE: begin
                if (abort)                state_next = S_IDLE;
                else if (vec_write_ready) state_next = is_last ? S_DONE : S_WAIT_RD;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy             = 1'b0;
        done             = 1'b0;
        vec_write_enable = 1'b0;
        case (state)
            S_WAIT_RD: begin
                busy = 1'b1;
            end
            S_WRITE: begin
                busy             = 1'b1;
                vec_write_enable = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered pulses, latched configuration and tile datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_read_enable     <= 1'b0;
            aborted             <= 1'b0;
            mode_q              <= '0;
            shift_q             <= '0;
            clamp_q             <= '0;
            len_q               <= '0;
            last_idx_q          <= '0;
            vec_read_buffer_id  <= '0;
            vec_write_buffer_id <= '0;
            vec_write_tile      <= '0;
            vec_tile_index      <= '0;
        end else begin
            // read request is a single-cycle pulse on entry to WAIT_RD
            vec_read_enable <= (launch && !len_zero) || (write_accept && !is_last);
            aborted         <= (state != S_IDLE) && abort;

            if (launch) begin
                mode_q              <= mode;
                shift_q             <= leaky_shift;
                clamp_q             <= clamp_max;
                len_q               <= length;
                last_idx_q          <= LEN_WIDTH'(tile_count - CNT_W'(1));
                vec_read_buffer_id  <= x_buffer_id;
                vec_write_buffer_id <= dest_buffer_id;
                vec_tile_index      <= '0;
            end

            if (read_capture) begin
                vec_write_tile <= act_tile;
            end

            if (write_accept && !is_last) begin
                vec_tile_index <= vec_tile_index + LEN_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_activation_execution.sv
module tb_activation_execution;

    localparam int DW = 8;
    localparam int TE = 32;
    localparam int LW = 10;
    localparam int BW = 5;
    localparam int TW = TE * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [1:0]    mode = '0;
    logic [2:0]    leaky_shift = '0;
    logic [DW-1:0] clamp_max = '0;
    logic [BW-1:0] x_buffer_id = '0;
    logic [BW-1:0] dest_buffer_id = '0;
    logic [LW-1:0] length = '0;
    logic          busy, done, aborted;
    logic          vec_read_enable;
    logic [BW-1:0] vec_read_buffer_id;
    logic [TW-1:0] vec_read_tile = '0;
    logic          vec_read_valid = 1'b0;
    logic          vec_write_enable;
    logic          vec_write_ready = 1'b0;
    logic [BW-1:0] vec_write_buffer_id;
    logic [TW-1:0] vec_write_tile;
    logic [LW-1:0] vec_tile_index;

    activation_execution dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .abort               (abort),
        .mode                (mode),
        .leaky_shift         (leaky_shift),
        .clamp_max           (clamp_max),
        .x_buffer_id         (x_buffer_id),
        .dest_buffer_id      (dest_buffer_id),
        .length              (length),
        .busy                (busy),
        .done                (done),
        .aborted             (aborted),
        .vec_read_enable     (vec_read_enable),
        .vec_read_buffer_id  (vec_read_buffer_id),
        .vec_read_tile       (vec_read_tile),
        .vec_read_valid      (vec_read_valid),
        .vec_write_enable    (vec_write_enable),
        .vec_write_ready     (vec_write_ready),
        .vec_write_buffer_id (vec_write_buffer_id),
        .vec_write_tile      (vec_write_tile),
        .vec_tile_index      (vec_tile_index)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // source memory and the configuration of the run in flight
    logic signed [DW-1:0] mem_x [0:1055];
    int m_mode, m_shift, m_cmax, m_len, m_xid, m_did, m_tiles;

    // responder knobs and observations
    int rd_lat = 1;
    int rr_rand = 0;
    int hold_left = 0;
    int blk_idx = -1;
    int rd_cd = -1;
    int rd_tidx = 0;
    int rd_cnt, wr_cnt, dn_cnt, ab_cnt, stall_cycles;
    bit prev_pend = 0;
    logic [TW-1:0] prev_tile;
    logic [TW-1:0] wr_first, wr_last;

    task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference activation in plain integer arithmetic
    function automatic int act(input int x);
        int r;
        int d;
        d = 1 << m_shift;
        case (m_mode)
            0: r = x;
            1: r = (x < 0) ? 0 : x;
            2: begin
                if (x >= 0) r = x;
                else begin
                    r = x / d;
                    if (r * d != x) r = r - 1;
                end
            end
            default: begin
                r = (x < 0) ? 0 : x;
                if (r > m_cmax) r = m_cmax;
                if (r < 0) r = 0;
            end
        endcase
        return r;
    endfunction

    function automatic logic [TW-1:0] model_tile(input int t);
        logic [TW-1:0] r;
        r = '0;
        for (int i = 0; i < TE; i++)
            if (t * TE + i < m_len) r[i*DW +: DW] = DW'(act(int'(mem_x[t*TE + i])));
        return r;
    endfunction

    function automatic logic [TW-1:0] src_tile(input int t);
        logic [TW-1:0] r;
        for (int i = 0; i < TE; i++) r[i*DW +: DW] = mem_x[t*TE + i];
        return r;
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < 1056; i++) mem_x[i] = DW'($urandom);
    endtask

    // memory / sink responder: drives inputs and samples outputs mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            vec_read_valid  = 1'b0;
            vec_write_ready = 1'b0;
            rd_cd           = -1;
            prev_pend       = 0;
        end else begin
            vec_read_valid = 1'b0;
            if (vec_read_enable) begin
                check("rd_buf", TW'(vec_read_buffer_id), TW'(m_xid));
                check("rd_idx", TW'(vec_tile_index), TW'(rd_cnt));
                rd_cnt++;
                rd_tidx = int'(vec_tile_index);
                rd_cd   = rd_lat;
            end
            if (rd_cd == 0) begin
                vec_read_valid = 1'b1;
                vec_read_tile  = src_tile(rd_tidx);
                rd_cd          = -1;
            end else if (rd_cd > 0) begin
                rd_cd--;
            end else if (vec_write_enable && $urandom_range(0, 3) == 0) begin
                // stray valid while writing must be ignored
                vec_read_valid = 1'b1;
                for (int i = 0; i < TW / 32; i++) vec_read_tile[i*32 +: 32] = $urandom;
            end

            if (vec_write_enable && hold_left > 0) begin
                vec_write_ready = 1'b0;
                hold_left--;
            end else if (vec_write_enable && int'(vec_tile_index) == blk_idx) begin
                vec_write_ready = 1'b0;
            end else begin
                vec_write_ready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end

            if (prev_pend && !aborted) begin
                check("hold_en", TW'(vec_write_enable), TW'(1));
                check("hold_tile", vec_write_tile, prev_tile);
                check("hold_no_rd", TW'(vec_read_enable), TW'(0));
            end

            if (vec_write_enable && vec_write_ready) begin
                check("wr_idx", TW'(vec_tile_index), TW'(wr_cnt));
                check("wr_buf", TW'(vec_write_buffer_id), TW'(m_did));
                check("wr_tile", vec_write_tile, model_tile(wr_cnt));
                if (wr_cnt == 0) wr_first = vec_write_tile;
                wr_last = vec_write_tile;
                wr_cnt++;
            end
            if (vec_write_enable && !vec_write_ready) stall_cycles++;
            prev_pend = vec_write_enable && !vec_write_ready;
            prev_tile = vec_write_tile;
            if (done) dn_cnt++;
            if (aborted) ab_cnt++;
        end
    end

    task automatic set_cfg(input int md, input int sh, input int cm, input int ln);
        m_mode  = md;
        m_shift = sh;
        m_cmax  = cm;
        m_len   = ln;
        m_xid   = int'($urandom_range(0, 31));
        m_did   = int'($urandom_range(0, 31));
        m_tiles = (ln + TE - 1) / TE;
    endtask

    task automatic launch(input bit poke);
        @(negedge clk);
        rd_cnt = 0; wr_cnt = 0; dn_cnt = 0; ab_cnt = 0; stall_cycles = 0;
        mode           = 2'(m_mode);
        leaky_shift    = 3'(m_shift);
        clamp_max      = DW'(m_cmax);
        x_buffer_id    = BW'(m_xid);
        dest_buffer_id = BW'(m_did);
        length         = LW'(m_len);
        start          = 1'b1;
        @(negedge clk);
        start          = poke;
        // later config changes must not affect the run in flight
        mode           = 2'($urandom);
        leaky_shift    = 3'($urandom);
        clamp_max      = DW'($urandom);
        x_buffer_id    = BW'($urandom);
        dest_buffer_id = BW'($urandom);
        length         = LW'($urandom_range(1, 1023));
        check("busy_after_start", TW'(busy), TW'(1));
        if (poke) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic wait_end(output bit got_done, output int cycles);
        got_done = 0;
        cycles   = 0;
        for (int c = 0; c < 4000; c++) begin
            if (done) begin
                got_done = 1;
                break;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic run(input int md, input int sh, input int cm, input int ln,
                       input int lat, input int rr, input bit poke);
        bit gd;
        int cyc;
        rd_lat  = lat;
        rr_rand = rr;
        set_cfg(md, sh, cm, ln);
        launch(poke && ln > 0);
        wait_end(gd, cyc);
        check("done_seen", TW'(gd), TW'(1));
        if (ln == 0) check("len0_done_latency", TW'(cyc), TW'(0));
        @(negedge clk);
        check("done_one_cycle", TW'(done), TW'(0));
        check("busy_after_done", TW'(busy), TW'(0));
        check("done_count", TW'(dn_cnt), TW'(1));
        check("abort_count", TW'(ab_cnt), TW'(0));
        check("read_count", TW'(rd_cnt), TW'(m_tiles));
        check("write_count", TW'(wr_cnt), TW'(m_tiles));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, TW'(busy), TW'(0));
        check({tag, "_done"}, TW'(done), TW'(0));
        check({tag, "_aborted"}, TW'(aborted), TW'(0));
        check({tag, "_rd_en"}, TW'(vec_read_enable), TW'(0));
        check({tag, "_wr_en"}, TW'(vec_write_enable), TW'(0));
        check({tag, "_wr_tile"}, vec_write_tile, TW'(0));
        check({tag, "_idx"}, TW'(vec_tile_index), TW'(0));
        check({tag, "_rd_buf"}, TW'(vec_read_buffer_id), TW'(0));
        check({tag, "_wr_buf"}, TW'(vec_write_buffer_id), TW'(0));
    endtask

    initial begin
        bit found;
        fill_mem();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // RELU, 70 elements over three tiles, ready tied high, extra start while busy
        fill_mem();
        mem_x[0] = -8'sd5;
        mem_x[1] = 8'sd7;
        run(1, 0, 0, 70, 1, 0, 1);
        check("relu_neg", TW'(wr_first[7:0]), TW'(8'h00));
        check("relu_pos", TW'(wr_first[15:8]), TW'(8'h07));
        check("tail_lanes_zero", TW'(wr_last[TW-1:6*DW]), TW'(0));

        // LEAKY shift 2, zero read latency
        fill_mem();
        mem_x[0] = -8'sd8;
        mem_x[1] = -8'sd1;
        mem_x[2] = 8'sd100;
        run(2, 2, 0, 3, 0, 0, 1);
        check("leaky_m8", TW'(wr_first[7:0]), TW'(8'hFE));
        check("leaky_m1", TW'(wr_first[15:8]), TW'(8'hFF));
        check("leaky_100", TW'(wr_first[23:16]), TW'(8'd100));

        // IDENTITY
        fill_mem();
        mem_x[0] = -8'sd128;
        run(0, 0, 0, 1, 2, 0, 0);
        check("ident_m128", TW'(wr_first[7:0]), TW'(8'h80));

        // CLAMP to 6, then negative bound
        fill_mem();
        mem_x[0] = -8'sd3;
        mem_x[1] = 8'sd4;
        mem_x[2] = 8'sd127;
        run(3, 0, 6, 3, 1, 0, 1);
        check("clamp_m3", TW'(wr_first[7:0]), TW'(8'd0));
        check("clamp_4", TW'(wr_first[15:8]), TW'(8'd4));
        check("clamp_127", TW'(wr_first[23:16]), TW'(8'd6));
        fill_mem();
        run(3, 0, -1, 40, 1, 1, 0);
        check("clamp_neg_all0", wr_last, TW'(0));

        // write ready held low for 5 cycles on the first tile
        fill_mem();
        hold_left = 5;
        run(1, 0, 0, 64, 1, 0, 0);
        check("stall_cycles", TW'(stall_cycles), TW'(5));

        // abort while tile 1 of 3 is waiting to be written
        fill_mem();
        rd_lat  = 1;
        rr_rand = 0;
        blk_idx = 1;
        set_cfg(2, 3, 0, 96);
        launch(0);
        found = 0;
        for (int c = 0; c < 200; c++) begin
            if (vec_write_enable && vec_tile_index == LW'(1)) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("abort_reached_write1", TW'(found), TW'(1));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        blk_idx = -1;
        check("abort_pulse", TW'(aborted), TW'(1));
        check("abort_busy", TW'(busy), TW'(0));
        check("abort_wr_en", TW'(vec_write_enable), TW'(0));
        check("abort_rd_en", TW'(vec_read_enable), TW'(0));
        @(negedge clk);
        check("abort_one_cycle", TW'(aborted), TW'(0));
        check("abort_no_done", TW'(dn_cnt), TW'(0));
        check("abort_reads", TW'(rd_cnt), TW'(2));
        check("abort_writes", TW'(wr_cnt), TW'(1));
        abort = 1'b1;  // abort in IDLE has no effect
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort_ignored", TW'(aborted), TW'(0));
        fill_mem();
        run(1, 0, 0, 96, 1, 0, 0);

        // zero length
        run(1, 0, 0, 0, 1, 0, 0);

        // asynchronous reset while waiting for read data
        fill_mem();
        rd_lat  = 30;
        rr_rand = 0;
        set_cfg(1, 0, 0, 64);
        launch(0);
        repeat (3) @(negedge clk);
        check("pre_reset_busy", TW'(busy), TW'(1));
        #2 rst = 1'b1;
        #1 check_idle_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_no_done", TW'(dn_cnt), TW'(0));
        check("rst_no_abort", TW'(ab_cnt), TW'(0));

        // randomized runs
        for (int k = 0; k < 8; k++) begin
            fill_mem();
            run(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 255)) - 128, int'($urandom_range(1, 300)),
                int'($urandom_range(0, 3)), 1, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
